// File: rtl/vga_timing_gen.sv
// Pixel-clock VGA timing generator: raster counters, delayed sync/DE/RGB aligned to a
// PIPE_LAT-cycle color lookup, and a framebuffer flip handshake taken at vblank start.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 29,
    parameter int PIPE_LAT = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [9:0]  sx_o,
    output logic [9:0]  sy_o,
    input  logic [14:0] color_i,
    output logic [4:0]  vga_r_o,
    output logic [4:0]  vga_g_o,
    output logic [4:0]  vga_b_o,
    output logic        vga_hs_o,
    output logic        vga_vs_o,
    output logic        vga_de_o,
    output logic        frame_start_o,
    output logic        vblank_start_o,
    input  logic        swap_req_i,
    output logic        swap_ack_o,
    output logic        buffer_sel_o
);

    localparam logic [9:0] H_MAX  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_MAX  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pipeline carries sync as "active" flags; polarity is applied only at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } ctl_t;

    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    ctl_t        raw;
    ctl_t        last;
    ctl_t        pipe_q [PIPE_LAT];
    logic        hs_q, vs_q, de_q;
    logic [14:0] rgb_q;
    logic        ack_q, buf_q;
    logic        vblank_start;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_MAX) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + 10'd1;
        end
    end

    assign raw.hs = (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
    assign raw.vs = (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);
    assign raw.de = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign last   = pipe_q[PIPE_LAT-1];

    assign vblank_start = (hcnt_q == '0) && (vcnt_q == V_ACT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            de_q   <= 1'b0;
            rgb_q  <= '0;
            ack_q  <= 1'b0;
            buf_q  <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            pipe_q[0] <= raw;
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            hs_q  <= last.hs ? SYNC_POL : ~SYNC_POL;
            vs_q  <= last.vs ? SYNC_POL : ~SYNC_POL;
            de_q  <= last.de;
            // Blanking forces black so an undriven color bus never reaches the DAC.
            rgb_q <= last.de ? color_i : '0;
            ack_q <= vblank_start && swap_req_i;
            if (vblank_start && swap_req_i) buf_q <= ~buf_q;
        end
    end

    assign sx_o           = hcnt_q;
    assign sy_o           = vcnt_q;
    assign vga_r_o        = rgb_q[4:0];
    assign vga_g_o        = rgb_q[9:5];
    assign vga_b_o        = rgb_q[14:10];
    assign vga_hs_o       = hs_q;
    assign vga_vs_o       = vs_q;
    assign vga_de_o       = de_q;
    assign frame_start_o  = (hcnt_q == '0) && (vcnt_q == '0);
    assign vblank_start_o = vblank_start;
    assign swap_ack_o     = ack_q;
    assign buffer_sel_o   = buf_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunk raster: outputs are predicted from elapsed
// cycles since reset (position = t mod line/frame) with random flips, resets and blank-time color.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 3, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int PL = 2;
    localparam bit POL = 1'b1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  sx_o, sy_o;
    logic [14:0] color_i;
    logic [4:0]  vga_r_o, vga_g_o, vga_b_o;
    logic        vga_hs_o, vga_vs_o, vga_de_o;
    logic        frame_start_o, vblank_start_o;
    logic        swap_req_i, swap_ack_o, buffer_sel_o;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_LAT(PL), .SYNC_POL(POL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sx_o(sx_o), .sy_o(sy_o), .color_i(color_i),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
        .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .vga_de_o(vga_de_o),
        .frame_start_o(frame_start_o), .vblank_start_o(vblank_start_o),
        .swap_req_i(swap_req_i), .swap_ack_o(swap_ack_o), .buffer_sel_o(buffer_sel_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int k;          // cycles since the last reset edge
    bit eb, ea;     // expected buffer_sel / swap_ack
    bit req;
    bit cnt_en = 1'b0;
    int fs_n, hs_n, hs_run, vs_n, de_n;
    bit prev_hs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    function automatic int hpos(input int t); return t % HT; endfunction
    function automatic int vpos(input int t); return (t / HT) % VT; endfunction
    function automatic bit active(input int t); return hpos(t) < HA && vpos(t) < VA; endfunction

    function automatic logic [14:0] color_of(input int t);
        logic [9:0] h, v;
        h = 10'(hpos(t));
        v = 10'(vpos(t));
        return {v[4:0], h[4:0], h[9:5]};
    endfunction

    // Renderer: valid color two cycles after the position, garbage during blanking.
    function automatic logic [14:0] color_at(input int c);
        if (c - 2 >= 0 && active(c - 2)) return color_of(c - 2);
        return 15'($urandom);
    endfunction

    task automatic check_now();
        int h, v, d;
        bit eh, ev, ede, act;
        h = hpos(k);
        v = vpos(k);
        d = k - (PL + 1);
        eh = 1'b0; ev = 1'b0; ede = 1'b0;
        if (d >= 0) begin
            ede = active(d);
            eh  = hpos(d) >= HA + HF && hpos(d) < HA + HF + HS;
            ev  = vpos(d) >= VA + VF && vpos(d) < VA + VF + VS;
        end
        chk("sx", sx_o, h);
        chk("sy", sy_o, v);
        chk("frame_start", frame_start_o, h == 0 && v == 0);
        chk("vblank_start", vblank_start_o, h == 0 && v == VA);
        chk("vga_de", vga_de_o, ede);
        chk("vga_hs", vga_hs_o, eh ? POL : !POL);
        chk("vga_vs", vga_vs_o, ev ? POL : !POL);
        chk("rgb", {vga_b_o, vga_g_o, vga_r_o}, ede ? color_of(d) : 15'd0);
        chk("swap_ack", swap_ack_o, ea);
        chk("buffer_sel", buffer_sel_o, eb);
        if (cnt_en) begin
            fs_n += int'(frame_start_o);
            de_n += int'(vga_de_o);
            vs_n += int'(vga_vs_o == POL);
            act = (vga_hs_o == POL);
            if (act) begin
                if (!prev_hs) hs_n++;
                hs_run++;
            end else if (prev_hs) begin
                chk("hs_width", hs_run, HS);
                hs_run = 0;
            end
            prev_hs = act;
        end
    endtask

    task automatic cycle(input bit rst_v, input bit req_v);
        bit vbs;
        check_now();
        rst_i      = rst_v;
        swap_req_i = req_v;
        color_i    = color_at(k);
        vbs = hpos(k) == 0 && vpos(k) == VA;
        if (rst_v) begin
            k = 0; eb = 1'b0; ea = 1'b0;
        end else begin
            ea = vbs && req_v;
            if (ea) eb = ~eb;
            k++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_to(input int h, input int v, input bit req_v);
        int n;
        n = 0;
        while (!(hpos(k) == h && vpos(k) == v) && n < HT * VT + 2) begin
            cycle(1'b0, req_v);
            n++;
        end
        if (n >= HT * VT + 2) chk("run_to_timeout", 0, 1);
    endtask

    task automatic hold_until_ack();
        int n;
        n = 0;
        while (!ea && n < 2 * HT * VT + 2) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        if (!ea) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        rst_i = 1'b1; swap_req_i = 1'b0; color_i = '0;
        @(posedge clk_i);
        #1;
        k = 0; eb = 1'b0; ea = 1'b0;
        cycle(1'b1, 1'b1);   // request held across reset must be dropped

        // One whole frame from release: aggregate sync/DE statistics.
        fs_n = 0; hs_n = 0; hs_run = 0; vs_n = 0; de_n = 0; prev_hs = 1'b0;
        cnt_en = 1'b1;
        for (int i = 0; i < HT * VT; i++) cycle(1'b0, 1'b0);
        cnt_en = 1'b0;
        chk("frame_starts", fs_n, 1);
        chk("hs_pulses", hs_n, VT);
        chk("vs_cycles", vs_n, VS * HT);
        chk("de_cycles", de_n, HA * VA);

        // Early request: flip at this frame's vblank, then none once dropped.
        run_to(0, 4, 1'b0);
        hold_until_ack();
        chk("ack_line", vpos(k) * HT + hpos(k), VA * HT + 1);
        for (int i = 0; i < HT * VT; i++) cycle(1'b0, 1'b0);

        // Late request: must wait for the next frame's vblank.
        run_to(0, VA + 2, 1'b0);
        hold_until_ack();
        chk("late_ack_line", vpos(k) * HT + hpos(k), VA * HT + 1);

        // Mid-frame reset pulse.
        run_to(10, 7, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0);

        // Random renderer traffic with occasional resets.
        req = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (!req && $urandom_range(0, 99) == 0) req = 1'b1;
            cycle($urandom_range(0, 2999) == 0, req);
            if (ea && $urandom_range(0, 3) != 0) req = 1'b0;
        end
        check_now();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
